// File: rtl/tl_tx_pkg.sv
// Shared types and constants for the TL transmit scheduler.
// Credit gating is compiled in only when TL_TX_FC_CHECK_EN is defined.
package tl_tx_pkg;

   localparam logic [2:0] BEAT_IDLE     = 3'b000;
   localparam logic [2:0] BEAT_P_HDR    = 3'b001;
   localparam logic [2:0] BEAT_P_DATA   = 3'b010;
   localparam logic [2:0] BEAT_NP_HDR   = 3'b011;
   localparam logic [2:0] BEAT_CPL_HDR  = 3'b101;
   localparam logic [2:0] BEAT_CPL_DATA = 3'b110;
   localparam logic [2:0] BEAT_DONE     = 3'b111;

   typedef enum logic [1:0] {CLS_P, CLS_NP, CLS_CPL} tl_class_e;
   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DONE} tx_state_e;

   localparam int unsigned CREDIT_PER_BEAT = 2;
   localparam int unsigned DW_PER_BEAT     = 8;

`ifdef TL_TX_FC_CHECK_EN
   localparam bit FC_CHECK_EN = 1'b1;
`else
   localparam bit FC_CHECK_EN = 1'b0;
`endif

   function automatic logic [2:0] hdr_code(input tl_class_e c);
      case (c)
         CLS_NP:  return BEAT_NP_HDR;
         CLS_CPL: return BEAT_CPL_HDR;
         default: return BEAT_P_HDR;
      endcase
   endfunction

   function automatic logic [2:0] data_code(input tl_class_e c);
      return (c == CLS_CPL) ? BEAT_CPL_DATA : BEAT_P_DATA;
   endfunction

   function automatic tl_class_e next_class(input tl_class_e c);
      case (c)
         CLS_P:   return CLS_NP;
         CLS_NP:  return CLS_CPL;
         default: return CLS_P;
      endcase
   endfunction

   // First eligible class scanning from ptr in P -> NP -> CPL order.
   function automatic tl_class_e rr_pick(input logic [2:0] elig, input tl_class_e ptr);
      tl_class_e c;
      tl_class_e pick;
      logic      found;
      c     = ptr;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (!found && elig[c]) begin
            pick  = c;
            found = 1'b1;
         end
         c = next_class(c);
      end
      return pick;
   endfunction

endpackage

// File: rtl/tl_fc_gate.sv
// One flow-control credit type: latched partner limit, consumed counter and
// the modular "need fits within limit" compare.
module tl_fc_gate #(
   parameter int unsigned CREDIT_DEPTH = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [CREDIT_DEPTH-1:0] limit,
   input  logic                    load,
   input  logic [CREDIT_DEPTH-1:0] need,
   input  logic                    consume,
   output logic                    fits,
   output logic [CREDIT_DEPTH-1:0] consumed
);

   logic [CREDIT_DEPTH-1:0] limit_q;
   logic [CREDIT_DEPTH-1:0] slack;

   // Fits when the wrapped slack lands in the lower half of the credit space.
   assign slack = limit_q - (consumed + need);
   assign fits  = ~slack[CREDIT_DEPTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         limit_q  <= '0;
         consumed <= '0;
      end else begin
         if (load)
            limit_q <= limit;
         if (consume)
            consumed <= consumed + need;
      end
   end

endmodule

// File: rtl/tl_tx_scheduler.sv
// Round-robin P/NP/CPL transmit scheduler feeding the DLL TL write interface.
// Define TL_TX_FC_CHECK_EN to gate grants on link-partner credit.
module tl_tx_scheduler
   import tl_tx_pkg::*;
#(
   parameter int unsigned PIPE_DATA_WIDTH = 256,
   parameter int unsigned CREDIT_DEPTH    = 12,
   parameter int unsigned RETRY_DEPTH_LG2 = 8,
   parameter int unsigned MAX_PLD_BEATS   = 8,
   localparam int unsigned LEN_W          = $clog2(MAX_PLD_BEATS + 1)
) (
   input  logic                         sclk,
   input  logic                         srst_n,
   input  logic                         p_valid_i,
   input  logic                         np_valid_i,
   input  logic                         cpl_valid_i,
   input  logic [PIPE_DATA_WIDTH-1:0]   p_hdr_i,
   input  logic [PIPE_DATA_WIDTH-1:0]   np_hdr_i,
   input  logic [PIPE_DATA_WIDTH-1:0]   cpl_hdr_i,
   input  logic [LEN_W-1:0]             p_len_i,
   input  logic [LEN_W-1:0]             cpl_len_i,
   output logic                         p_ready_o,
   output logic                         np_ready_o,
   output logic                         cpl_ready_o,
   input  logic [PIPE_DATA_WIDTH-1:0]   pld_data_i,
   input  logic                         pld_valid_i,
   output logic                         pld_ready_o,
   input  logic [CREDIT_DEPTH-1:0]      ep_cl_p_h_i,
   input  logic [CREDIT_DEPTH-1:0]      ep_cl_p_d_i,
   input  logic [CREDIT_DEPTH-1:0]      ep_cl_np_h_i,
   input  logic [CREDIT_DEPTH-1:0]      ep_cl_cpl_h_i,
   input  logic [CREDIT_DEPTH-1:0]      ep_cl_cpl_d_i,
   input  logic                         ep_cl_en_i,
   input  logic [RETRY_DEPTH_LG2+2:0]   retry_space_i,
   output logic [CREDIT_DEPTH-1:0]      cc_p_h_o,
   output logic [CREDIT_DEPTH-1:0]      cc_p_d_o,
   output logic [CREDIT_DEPTH-1:0]      cc_np_h_o,
   output logic [CREDIT_DEPTH-1:0]      cc_cpl_h_o,
   output logic [CREDIT_DEPTH-1:0]      cc_cpl_d_o,
   output logic [PIPE_DATA_WIDTH-1:0]   tl2dll_data_o,
   output logic [2:0]                   tl2dll_en_o
);

   localparam int unsigned RW = RETRY_DEPTH_LG2 + 3;
   localparam logic [CREDIT_DEPTH-1:0] HDR_NEED = CREDIT_DEPTH'(1);
   localparam logic [RW-1:0] RETRY_NP = RW'(DW_PER_BEAT);

   tx_state_e                state;
   tl_class_e                rr;
   tl_class_e                cls;
   tl_class_e                win;
   logic [LEN_W-1:0]         remain;
   logic [LEN_W-1:0]         win_len;
   logic [PIPE_DATA_WIDTH-1:0] win_hdr;
   logic                     fc_init;
   logic [2:0]               elig;
   logic [2:0]               grant;
   logic [CREDIT_DEPTH-1:0]  need_p_d;
   logic [CREDIT_DEPTH-1:0]  need_cpl_d;
   logic [RW-1:0]            retry_p;
   logic [RW-1:0]            retry_cpl;
   logic fits_p_h, fits_p_d, fits_np_h, fits_cpl_h, fits_cpl_d;

   assign need_p_d   = CREDIT_DEPTH'(CREDIT_PER_BEAT * p_len_i);
   assign need_cpl_d = CREDIT_DEPTH'(CREDIT_PER_BEAT * cpl_len_i);
   assign retry_p    = RW'(DW_PER_BEAT * (p_len_i + 1));
   assign retry_cpl  = RW'(DW_PER_BEAT * (cpl_len_i + 1));

   assign elig[0] = p_valid_i && fc_init && (retry_space_i >= retry_p) &&
                    (!FC_CHECK_EN || (fits_p_h && fits_p_d));
   assign elig[1] = np_valid_i && fc_init && (retry_space_i >= RETRY_NP) &&
                    (!FC_CHECK_EN || fits_np_h);
   assign elig[2] = cpl_valid_i && fc_init && (retry_space_i >= retry_cpl) &&
                    (!FC_CHECK_EN || (fits_cpl_h && fits_cpl_d));

   always_comb begin
      win     = rr_pick(elig, rr);
      grant   = ((state == ST_IDLE) && (|elig)) ? (3'b001 << win) : 3'b000;
      win_hdr = p_hdr_i;
      win_len = p_len_i;
      case (win)
         CLS_NP: begin
            win_hdr = np_hdr_i;
            win_len = '0;
         end
         CLS_CPL: begin
            win_hdr = cpl_hdr_i;
            win_len = cpl_len_i;
         end
         default: ;
      endcase
   end

   assign p_ready_o   = grant[0];
   assign np_ready_o  = grant[1];
   assign cpl_ready_o = grant[2];
   assign pld_ready_o = (state == ST_DATA);

   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         state         <= ST_IDLE;
         rr            <= CLS_P;
         cls           <= CLS_P;
         remain        <= '0;
         fc_init       <= 1'b0;
         tl2dll_en_o   <= BEAT_IDLE;
         tl2dll_data_o <= '0;
      end else begin
         fc_init     <= fc_init | ep_cl_en_i;
         tl2dll_en_o <= BEAT_IDLE;
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  tl2dll_en_o   <= hdr_code(win);
                  tl2dll_data_o <= win_hdr;
                  cls           <= win;
                  remain        <= win_len;
                  rr            <= next_class(win);
                  state         <= (win_len != '0) ? ST_DATA : ST_DONE;
               end
            end
            ST_DATA: begin
               if (pld_valid_i) begin
                  tl2dll_en_o   <= data_code(cls);
                  tl2dll_data_o <= pld_data_i;
                  remain        <= remain - LEN_W'(1);
                  if (remain == LEN_W'(1))
                     state <= ST_DONE;
               end
            end
            default: begin
               tl2dll_en_o <= BEAT_DONE;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   tl_fc_gate #(.CREDIT_DEPTH(CREDIT_DEPTH)) u_gate_p_h (
      .clk(sclk), .rst_n(srst_n), .limit(ep_cl_p_h_i), .load(ep_cl_en_i),
      .need(HDR_NEED), .consume(grant[0]), .fits(fits_p_h), .consumed(cc_p_h_o));

   tl_fc_gate #(.CREDIT_DEPTH(CREDIT_DEPTH)) u_gate_p_d (
      .clk(sclk), .rst_n(srst_n), .limit(ep_cl_p_d_i), .load(ep_cl_en_i),
      .need(need_p_d), .consume(grant[0]), .fits(fits_p_d), .consumed(cc_p_d_o));

   tl_fc_gate #(.CREDIT_DEPTH(CREDIT_DEPTH)) u_gate_np_h (
      .clk(sclk), .rst_n(srst_n), .limit(ep_cl_np_h_i), .load(ep_cl_en_i),
      .need(HDR_NEED), .consume(grant[1]), .fits(fits_np_h), .consumed(cc_np_h_o));

   tl_fc_gate #(.CREDIT_DEPTH(CREDIT_DEPTH)) u_gate_cpl_h (
      .clk(sclk), .rst_n(srst_n), .limit(ep_cl_cpl_h_i), .load(ep_cl_en_i),
      .need(HDR_NEED), .consume(grant[2]), .fits(fits_cpl_h), .consumed(cc_cpl_h_o));

   tl_fc_gate #(.CREDIT_DEPTH(CREDIT_DEPTH)) u_gate_cpl_d (
      .clk(sclk), .rst_n(srst_n), .limit(ep_cl_cpl_d_i), .load(ep_cl_en_i),
      .need(need_cpl_d), .consume(grant[2]), .fits(fits_cpl_d), .consumed(cc_cpl_d_o));

endmodule

// File: tb/tb_tl_tx_scheduler.sv
// Scoreboard bench for tl_tx_scheduler; expected beats are queued at each
// handshake and popped as the DLL-side beats appear.
module tb_tl_tx_scheduler;

   localparam int PW = 256;
   localparam int CD = 12;
   localparam int LW = 4;
   localparam int RW = 11;
   localparam int PH = 0, PD = 1, NPH = 2, CPLH = 3, CPLD = 4;
`ifdef TL_TX_FC_CHECK_EN
   localparam bit FC = 1'b1;
`else
   localparam bit FC = 1'b0;
`endif

   logic          sclk, srst_n;
   logic          p_valid_i, np_valid_i, cpl_valid_i;
   logic [PW-1:0] p_hdr_i, np_hdr_i, cpl_hdr_i;
   logic [LW-1:0] p_len_i, cpl_len_i;
   logic          p_ready_o, np_ready_o, cpl_ready_o;
   logic [PW-1:0] pld_data_i;
   logic          pld_valid_i, pld_ready_o;
   logic [CD-1:0] ep_cl_p_h_i, ep_cl_p_d_i, ep_cl_np_h_i, ep_cl_cpl_h_i, ep_cl_cpl_d_i;
   logic          ep_cl_en_i;
   logic [RW-1:0] retry_space_i;
   logic [CD-1:0] cc_p_h_o, cc_p_d_o, cc_np_h_o, cc_cpl_h_o, cc_cpl_d_o;
   logic [PW-1:0] tl2dll_data_o;
   logic [2:0]    tl2dll_en_o;

   tl_tx_scheduler #(
      .PIPE_DATA_WIDTH(PW), .CREDIT_DEPTH(CD), .RETRY_DEPTH_LG2(8), .MAX_PLD_BEATS(8)
   ) dut (
      .sclk(sclk), .srst_n(srst_n),
      .p_valid_i(p_valid_i), .np_valid_i(np_valid_i), .cpl_valid_i(cpl_valid_i),
      .p_hdr_i(p_hdr_i), .np_hdr_i(np_hdr_i), .cpl_hdr_i(cpl_hdr_i),
      .p_len_i(p_len_i), .cpl_len_i(cpl_len_i),
      .p_ready_o(p_ready_o), .np_ready_o(np_ready_o), .cpl_ready_o(cpl_ready_o),
      .pld_data_i(pld_data_i), .pld_valid_i(pld_valid_i), .pld_ready_o(pld_ready_o),
      .ep_cl_p_h_i(ep_cl_p_h_i), .ep_cl_p_d_i(ep_cl_p_d_i), .ep_cl_np_h_i(ep_cl_np_h_i),
      .ep_cl_cpl_h_i(ep_cl_cpl_h_i), .ep_cl_cpl_d_i(ep_cl_cpl_d_i), .ep_cl_en_i(ep_cl_en_i),
      .retry_space_i(retry_space_i),
      .cc_p_h_o(cc_p_h_o), .cc_p_d_o(cc_p_d_o), .cc_np_h_o(cc_np_h_o),
      .cc_cpl_h_o(cc_cpl_h_o), .cc_cpl_d_o(cc_cpl_d_o),
      .tl2dll_data_o(tl2dll_data_o), .tl2dll_en_o(tl2dll_en_o)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   typedef struct {
      logic [2:0]    code;
      logic [PW-1:0] data;
      bit            chk_data;
   } beat_t;

   beat_t         exp_q[$];
   int            n_tests, n_fails;
   logic [CD-1:0] m_cc[5];
   logic [CD-1:0] lim[5];
   int            m_rr;

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge sclk) begin
      if (srst_n && tl2dll_en_o != 3'b000) begin
         beat_t e;
         if (exp_q.size() == 0) begin
            check("unexpected_beat", tl2dll_en_o, 0);
         end else begin
            e = exp_q.pop_front();
            check("beat_code", tl2dll_en_o, e.code);
            if (e.chk_data) check("beat_data", tl2dll_data_o, e.data);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   function automatic logic [PW-1:0] rnd256();
      logic [PW-1:0] d;
      for (int i = 0; i < PW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic bit rdy(input int c);
      case (c)
         0:       return p_ready_o;
         1:       return np_ready_o;
         default: return cpl_ready_o;
      endcase
   endfunction

   task automatic push_beat(input logic [2:0] code, input logic [PW-1:0] data, input bit chk);
      beat_t b;
      b.code = code; b.data = data; b.chk_data = chk;
      exp_q.push_back(b);
   endtask

   task automatic set_req(input int c, input bit v, input int len, input logic [PW-1:0] hdr);
      case (c)
         0: begin p_valid_i = v; p_len_i = LW'(len); p_hdr_i = hdr; end
         1: begin np_valid_i = v; np_hdr_i = hdr; end
         default: begin cpl_valid_i = v; cpl_len_i = LW'(len); cpl_hdr_i = hdr; end
      endcase
   endtask

   task automatic load_limits();
      ep_cl_p_h_i = lim[PH]; ep_cl_p_d_i = lim[PD]; ep_cl_np_h_i = lim[NPH];
      ep_cl_cpl_h_i = lim[CPLH]; ep_cl_cpl_d_i = lim[CPLD];
      ep_cl_en_i = 1'b1;
      @(posedge sclk); #1;
      ep_cl_en_i = 1'b0;
   endtask

   task automatic ample_limits();
      for (int i = 0; i < 5; i++) lim[i] = m_cc[i] + CD'(100);
      load_limits();
   endtask

   task automatic wait_grant(input int c, input int max, output bit got);
      got = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge sclk);
         if (rdy(c)) begin
            got = 1'b1;
            break;
         end
         @(posedge sclk); #1;
      end
   endtask

   task automatic on_grant(input int c, input int len, input logic [PW-1:0] hdr, input bit keep);
      push_beat((c == 0) ? 3'b001 : (c == 1) ? 3'b011 : 3'b101, hdr, 1'b1);
      case (c)
         0: begin m_cc[PH] = m_cc[PH] + CD'(1); m_cc[PD] = m_cc[PD] + CD'(2 * len); end
         1: m_cc[NPH] = m_cc[NPH] + CD'(1);
         default: begin m_cc[CPLH] = m_cc[CPLH] + CD'(1); m_cc[CPLD] = m_cc[CPLD] + CD'(2 * len); end
      endcase
      m_rr = (c + 1) % 3;
      @(posedge sclk); #1;
      if (!keep) set_req(c, 1'b0, len, hdr);
   endtask

   task automatic run_payload(input int c, input int len, input bit bubble);
      int b, guard;
      bit bub_chk;
      logic [PW-1:0] d;
      b = 0; guard = 0; bub_chk = 1'b0;
      d = rnd256(); pld_data_i = d; pld_valid_i = (len > 0);
      while (b < len && guard < 60) begin
         @(negedge sclk); guard++;
         if (bub_chk) begin
            check("bubble_en", tl2dll_en_o, 0);
            bub_chk = 1'b0;
         end
         if (pld_ready_o && pld_valid_i) begin
            push_beat((c == 2) ? 3'b110 : 3'b010, d, 1'b1);
            b++;
            @(posedge sclk); #1;
            if (bubble && b == 1 && b < len) begin
               pld_valid_i = 1'b0;
               @(posedge sclk); #1;
               bub_chk = 1'b1;
            end
            d = rnd256(); pld_data_i = d; pld_valid_i = (b < len);
         end else begin
            @(posedge sclk); #1;
         end
      end
      pld_valid_i = 1'b0;
      if (b < len) check("pld_timeout", b, len);
      push_beat(3'b111, '0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(negedge sclk); #1;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge sclk); #1;
   endtask

   task automatic finish_tlp(input int c, input int len, input logic [PW-1:0] hdr,
                             input bit got, input bit bubble);
      if (got) begin
         on_grant(c, len, hdr, 1'b0);
         run_payload(c, len, bubble);
         drain();
      end else begin
         set_req(c, 1'b0, len, hdr);
      end
   endtask

   task automatic send(input string tag, input int c, input int len, input bit bubble);
      logic [PW-1:0] hdr;
      bit got;
      hdr = rnd256();
      set_req(c, 1'b1, len, hdr);
      wait_grant(c, 20, got);
      check(tag, got, 1);
      finish_tlp(c, len, hdr, got, bubble);
   endtask

   task automatic check_cc();
      check("cc_p_h", cc_p_h_o, m_cc[PH]);
      check("cc_p_d", cc_p_d_o, m_cc[PD]);
      check("cc_np_h", cc_np_h_o, m_cc[NPH]);
      check("cc_cpl_h", cc_cpl_h_o, m_cc[CPLH]);
      check("cc_cpl_d", cc_cpl_d_o, m_cc[CPLD]);
   endtask

   initial begin
      logic [PW-1:0] hdr;
      logic [PW-1:0] hdrs[3];
      bit got;
      n_tests = 0; n_fails = 0; m_rr = 0;
      for (int i = 0; i < 5; i++) begin m_cc[i] = '0; lim[i] = '0; end
      srst_n = 1'b0;
      p_valid_i = 0; np_valid_i = 0; cpl_valid_i = 0;
      p_hdr_i = '0; np_hdr_i = '0; cpl_hdr_i = '0; p_len_i = '0; cpl_len_i = '0;
      pld_data_i = '0; pld_valid_i = 0; ep_cl_en_i = 0;
      ep_cl_p_h_i = '0; ep_cl_p_d_i = '0; ep_cl_np_h_i = '0; ep_cl_cpl_h_i = '0; ep_cl_cpl_d_i = '0;
      retry_space_i = RW'(2047);
      #2;
      check("rst_en", tl2dll_en_o, 0);
      check("rst_data", tl2dll_data_o, 0);
      check("rst_pld_ready", pld_ready_o, 0);
      check_cc();
      repeat (3) @(posedge sclk);
      #1 srst_n = 1'b1;

      // Init gating: nothing issues until limits arrive.
      hdr = rnd256();
      set_req(0, 1'b1, 1, hdr);
      wait_grant(0, 20, got);
      check("init_gate", got, 0);
      check("init_en", tl2dll_en_o, 0);
      lim[PH] = CD'(4); lim[PD] = CD'(8);
      load_limits();
      wait_grant(0, 1, got);
      check("init_grant", got, 1);
      finish_tlp(0, 1, hdr, got, 1'b0);
      check_cc();

      // Posted writes with and without a payload bubble.
      lim[PH] = m_cc[PH] + CD'(50); lim[PD] = m_cc[PD] + CD'(50);
      load_limits();
      send("p2_grant", 0, 2, 1'b0);
      check_cc();
      send("p2b_grant", 0, 2, 1'b1);
      check_cc();

      // NP header credit stall.
      lim[NPH] = m_cc[NPH] + CD'(1);
      load_limits();
      send("np1_grant", 1, 0, 1'b0);
      hdr = rnd256();
      set_req(1, 1'b1, 0, hdr);
      wait_grant(1, 10, got);
      check("np_stall", got, !FC);
      if (!got) begin
         lim[NPH] = m_cc[NPH] + CD'(1);
         load_limits();
         wait_grant(1, 2, got);
         check("np_after_limit", got, 1);
      end
      finish_tlp(1, 0, hdr, got, 1'b0);
      check_cc();

      // Completion with data, then round-robin over all three classes.
      ample_limits();
      send("cpl_grant", 2, 2, 1'b0);
      for (int c = 0; c < 3; c++) begin
         hdrs[c] = rnd256();
         set_req(c, 1'b1, 0, hdrs[c]);
      end
      for (int k = 0; k < 6; k++) begin
         int gc, nr;
         gc = -1;
         for (int i = 0; i < 10; i++) begin
            @(negedge sclk);
            nr = int'(p_ready_o) + int'(np_ready_o) + int'(cpl_ready_o);
            if (nr != 0) begin
               check("rr_onehot", nr, 1);
               gc = p_ready_o ? 0 : (np_ready_o ? 1 : 2);
               break;
            end
            @(posedge sclk); #1;
         end
         check("rr_class", gc, m_rr);
         if (gc >= 0) begin
            on_grant(gc, 0, hdrs[gc], 1'b1);
            push_beat(3'b111, '0, 1'b0);
         end
      end
      for (int c = 0; c < 3; c++) set_req(c, 1'b0, 0, hdrs[c]);
      drain();
      check_cc();

      // Retry-buffer space boundary: P len 1 needs 16 DW.
      retry_space_i = RW'(15);
      hdr = rnd256();
      set_req(0, 1'b1, 1, hdr);
      wait_grant(0, 10, got);
      check("retry_stall", got, 0);
      retry_space_i = RW'(16);
      if (!got) begin
         wait_grant(0, 2, got);
         check("retry_grant", got, 1);
      end
      finish_tlp(0, 1, hdr, got, 1'b0);
      retry_space_i = RW'(2047);
      check_cc();

      // Walk cc_p_d up to 4094, then exercise the wrap boundary.
      for (int it = 0; it < 400 && m_cc[PD] != CD'(4094); it++) begin
         int r, len;
         r = (4094 - int'(m_cc[PD])) / 2;
         len = (r > 8) ? 8 : r;
         lim[PH] = m_cc[PH] + CD'(10); lim[PD] = m_cc[PD] + CD'(100);
         load_limits();
         send("bulk_grant", 0, len, 1'b0);
      end
      check("bulk_cc_p_d", cc_p_d_o, 4094);
      lim[PH] = m_cc[PH] + CD'(10); lim[PD] = CD'(4095);
      load_limits();
      hdr = rnd256();
      set_req(0, 1'b1, 1, hdr);
      wait_grant(0, 10, got);
      check("wrap_block", got, !FC);
      if (!got) begin
         lim[PD] = '0;
         load_limits();
         wait_grant(0, 2, got);
         check("wrap_grant", got, 1);
      end
      finish_tlp(0, 1, hdr, got, 1'b0);
      check("wrap_cc_p_d", cc_p_d_o, 0);
      check_cc();

      // Asynchronous reset in the middle of a payload.
      ample_limits();
      hdr = rnd256();
      set_req(0, 1'b1, 3, hdr);
      wait_grant(0, 20, got);
      check("rstmid_grant", got, 1);
      if (got) begin
         on_grant(0, 3, hdr, 1'b1);
         pld_data_i = rnd256();
         pld_valid_i = 1'b1;
         @(negedge sclk);
         @(posedge sclk);
         #3 srst_n = 1'b0;
         #1;
         exp_q.delete();
         for (int i = 0; i < 5; i++) m_cc[i] = '0;
         m_rr = 0;
         check("rstmid_en", tl2dll_en_o, 0);
         check("rstmid_data", tl2dll_data_o, 0);
         check("rstmid_pld_ready", pld_ready_o, 0);
         check("rstmid_p_ready", p_ready_o, 0);
         check_cc();
         pld_valid_i = 1'b0;
         #2 srst_n = 1'b1;
         @(posedge sclk); #1;
         wait_grant(0, 10, got);
         check("post_rst_gate", got, 0);
         for (int i = 0; i < 5; i++) lim[i] = CD'(100);
         load_limits();
         wait_grant(0, 1, got);
         check("post_rst_grant", got, 1);
         finish_tlp(0, 3, hdr, got, 1'b0);
         check_cc();
      end else begin
         set_req(0, 1'b0, 3, hdr);
      end

      check("final_q_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule

// File: doc/tl_tx_scheduler.md
Name: tl_tx_scheduler

Overview:
Transaction-layer transmit scheduler that sits directly upstream of the DLL top and drives its TL write interface (beat data plus the 3-bit beat code).
- Arbitrates round-robin among Posted, Non-Posted and Completion request sources.
- Gates each grant on link-partner flow-control credit and on retry-buffer space.
- Serialises the granted TLP as one header beat, N payload beats, then a DONE beat.
- Maintains its own transmit credits-consumed counters.

Parameters:
PIPE_DATA_WIDTH, 256, beat width in bits (8 DW).
CREDIT_DEPTH, 12, width of credit counters and limits; all credit arithmetic is modulo 2^CREDIT_DEPTH.
RETRY_DEPTH_LG2, 8, sets retry-space input width to RETRY_DEPTH_LG2+3.
MAX_PLD_BEATS, 8, maximum payload beats per TLP; LEN_W = $clog2(MAX_PLD_BEATS+1).

Ports:
- sclk  in  1  clock.
- srst_n  in  1  reset, asynchronous, active-low.
- p_valid_i / np_valid_i / cpl_valid_i  in  1 each  request pending per class.
- p_hdr_i / np_hdr_i / cpl_hdr_i  in  PIPE_DATA_WIDTH each  header beat.
- p_len_i / cpl_len_i  in  LEN_W each  payload beats (0 = header only). NP is always 0.
- p_ready_o / np_ready_o / cpl_ready_o  out  1 each  header accepted (one-cycle pulse).
- pld_data_i  in  PIPE_DATA_WIDTH  payload beat for the granted TLP.
- pld_valid_i  in  1  payload beat valid.
- pld_ready_o  out  1  payload beat accepted.
- ep_cl_p_h_i, ep_cl_p_d_i, ep_cl_np_h_i, ep_cl_cpl_h_i, ep_cl_cpl_d_i  in  CREDIT_DEPTH each  link-partner credit limits.
- ep_cl_en_i  in  1  limits valid/updated this cycle.
- retry_space_i  in  RETRY_DEPTH_LG2+3  free retry-buffer DW.
- cc_p_h_o, cc_p_d_o, cc_np_h_o, cc_cpl_h_o, cc_cpl_d_o  out  CREDIT_DEPTH each  credits consumed by transmitter.
- tl2dll_data_o  out  PIPE_DATA_WIDTH  beat data to DLL.
- tl2dll_en_o  out  3  beat code: 000 IDLE, 001 P_HDR, 010 P_DATA, 011 NP_HDR, 101 CPL_HDR, 110 CPL_DATA, 111 DONE; 100 is never driven.

Behaviour:
- Reset: all outputs 0, FSM IDLE, round-robin pointer at P, cc_* = 0, limit registers 0, fc_init = 0.
- Limits: ep_cl_en_i latches all five limits and sets fc_init (sticky until reset). No grant while fc_init = 0.
- Need per class:
  - hdr credit = 1.
  - data credit = 2*len (1 credit = 16 B, 1 beat = 32 B).
  - retry DW = 8*(1+len).
- Eligible = valid && fc_init && retry_space_i >= retry DW && for each needed type ((cl - (cc + need)) mod 2^CREDIT_DEPTH) < 2^(CREDIT_DEPTH-1).
- FSM states: IDLE, DATA, DONE.
- IDLE:
  - Choose the first eligible class at or after the RR pointer, in order P → NP → CPL.
  - Pulse that class's ready_o combinationally in the same cycle. The handshake is the grant.
  - Next cycle: tl2dll_en_o = class HDR code, tl2dll_data_o = header.
  - On grant: cc_h += 1 and cc_d += 2*len, registered. Latch class and len. RR pointer advances to the class after the winner.
  - Go to DATA if len > 0, else DONE.
  - With no grant, output code 000 next cycle; data holds its last value.
- DATA:
  - pld_ready_o = 1.
  - Each pld_valid_i beat is registered to the output with the class DATA code and decrements the remaining count.
  - A cycle with pld_valid_i low outputs 000 (bubble allowed).
  - After the last beat is accepted, go to DONE.
- DONE: output 111 next cycle, then IDLE. A header-only TLP uses 3 cycles from grant to next possible grant.
- Output latency: 1 cycle from handshake to tl2dll_* (registered outputs).
- ep_cl_en_i arriving in the same cycle as a grant: the eligibility check uses the old limits; the new limits take effect next cycle.
- Counters wrap naturally with no saturation.
- Async reset mid-TLP aborts immediately: no DONE is emitted, and counters return to 0.

Optional Feature:
TL_TX_FC_CHECK_EN
- Defined: credit comparisons gate eligibility as above.
- Undefined: credit terms are treated as always true; fc_init is still required and counters still update. Intended for bring-up against a partner with infinite credit.

Decomposition:
- Package tl_tx_pkg holds:
  - beat-code localparams (IDLE..DONE, 3-bit);
  - class enum {P, NP, CPL};
  - FSM state enum;
  - credit-per-beat and DW-per-beat constants.
- One sub-module tl_fc_gate, instanced per credit type. It owns one limit register and one consumed counter, and provides the modular "need fits" compare plus the increment.

Test Plan:
1. Init gating: p_valid_i = 1, len = 1, no ep_cl_en_i for 20 cycles → p_ready_o stays 0 and en stays 000. Then pulse ep_cl_en_i with cl_p_h = 4, cl_p_d = 8 → grant next cycle.
2. P write, len = 2, pld_valid_i high → en sequence 001, 010, 010, 111; cc_p_h 0 → 1, cc_p_d 0 → 4. With one pld bubble inserted, 000 appears between the 010 beats.
3. Credit stall: cl_np_h = 1, two NP requests → first issues 011, 111; second stalls until ep_cl_en_i with cl_np_h = 2, then issues.
4. Round-robin and retry space:
   - All classes valid, len = 0, ample credit → header order 001, 011, 101, 001, …
   - retry_space_i = 15 with P len = 1 → stall; at 16 → grant.
5. Wrap: cc_p_d = 4094, cl_p_d = 0, len = 1 → granted, cc_p_d becomes 0. Same state with cl_p_d = 4095 → blocked.
6. Reset: assert srst_n low mid-DATA (asynchronously, between clock edges) → all outputs 0 immediately, cc_* = 0. After release, no grant until ep_cl_en_i.
